// File: rtl/axis_lane_switch.sv
// AXI-Stream lane router: per-word pass/rotate/reverse/broadcast lane mapping
// into a registered output stage backed by a one-word skid register.
module axis_lane_switch #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LANE_COUNT       = 2
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [1:0]                            mode,
    input  logic [$clog2(LANE_COUNT)-1:0]         shift,
    input  logic [AXIS_TDATA_WIDTH-1:0]           S_AXIS_tdata,
    input  logic                                  S_AXIS_tvalid,
    output logic                                  S_AXIS_tready,
    input  logic                                  M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]           M_AXIS_tdata,
    output logic                                  M_AXIS_tvalid,
    output logic [31:0]                           word_count
);

    localparam int LANE_WIDTH = AXIS_TDATA_WIDTH / LANE_COUNT;
    localparam int SEL_WIDTH  = $clog2(LANE_COUNT);

    // Buffer occupancy encoded directly by {skid_valid, out_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    logic [AXIS_TDATA_WIDTH-1:0] mapped;
    logic [AXIS_TDATA_WIDTH-1:0] out_data;
    logic [AXIS_TDATA_WIDTH-1:0] skid_data;
    logic                        out_valid;
    logic                        skid_valid;
    logic                        s_ready;
    logic [31:0]                 cnt_q;
    logic                        accept;
    logic                        skid_next;
    state_e                      state;

    // Mapping happens before buffering so later config changes never touch stored words.
    always_comb begin
        mapped = '0;
        for (int i = 0; i < LANE_COUNT; i++) begin
            logic [SEL_WIDTH-1:0] j;
            j = '0;
            case (mode)
                2'd0:    j = SEL_WIDTH'(i);
                2'd1:    j = SEL_WIDTH'(i) + shift;
                2'd2:    j = SEL_WIDTH'(LANE_COUNT - 1 - i);
                default: j = shift;
            endcase
            mapped[i*LANE_WIDTH +: LANE_WIDTH] = S_AXIS_tdata[int'(j)*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_comb begin
        state = state_e'({skid_valid, out_valid});
        accept = S_AXIS_tvalid & s_ready;
        skid_next = 1'b0;
        case (state)
            ONE:     skid_next = accept & ~M_AXIS_tready;
            FULL:    skid_next = ~M_AXIS_tready;
            default: skid_next = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data   <= '0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            s_ready    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (out_valid && M_AXIS_tready) begin
                cnt_q <= cnt_q + 32'd1;
            end
            case (state)
                ONE: begin
                    if (accept && M_AXIS_tready) begin
                        out_data <= mapped;
                    end else if (accept) begin
                        skid_data  <= mapped;
                        skid_valid <= 1'b1;
                    end else if (M_AXIS_tready) begin
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (M_AXIS_tready) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        out_data  <= mapped;
                        out_valid <= 1'b1;
                    end
                end
            endcase
            s_ready <= ~skid_next;
        end
    end

    assign S_AXIS_tready = s_ready;
    assign M_AXIS_tdata  = out_data;
    assign M_AXIS_tvalid = out_valid;
    assign word_count    = cnt_q;

endmodule

// File: tb/tb_axis_lane_switch.sv
// Directed bench for axis_lane_switch: 4-lane instance with a scoreboard, plus a
// 2-lane instance for the legacy half-swap.
module tb_axis_lane_switch;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [1:0]  mode;
    logic [1:0]  shift;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic [31:0] word_count;

    logic [1:0]  mode2;
    logic [0:0]  shift2;
    logic [31:0] s2_tdata;
    logic        s2_tvalid;
    logic        s2_tready;
    logic [31:0] m2_tdata;
    logic        m2_tvalid;
    logic [31:0] word_count2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sbq[$];
    bit          last_acc;
    bit          m_rand = 0;
    int          out_hs = 0;

    always #5 aclk = ~aclk;

    axis_lane_switch #(.AXIS_TDATA_WIDTH(32), .LANE_COUNT(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .mode(mode), .shift(shift),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
        .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid),
        .word_count(word_count)
    );

    axis_lane_switch #(.AXIS_TDATA_WIDTH(32), .LANE_COUNT(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .mode(mode2), .shift(shift2),
        .S_AXIS_tdata(s2_tdata), .S_AXIS_tvalid(s2_tvalid), .S_AXIS_tready(s2_tready),
        .M_AXIS_tready(1'b1), .M_AXIS_tdata(m2_tdata), .M_AXIS_tvalid(m2_tvalid),
        .word_count(word_count2)
    );

    function automatic logic [31:0] model(input logic [31:0] d, input int m, input int sh);
        logic [31:0] r;
        int j;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (m)
                0:       j = i;
                1:       j = (i + sh) % 4;
                2:       j = 3 - i;
                default: j = sh;
            endcase
            r[i*8 +: 8] = d[j*8 +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample both handshakes at the falling edge, then step to posedge+1.
    task automatic tick();
        @(negedge aclk);
        last_acc = aresetn && s_tvalid && s_tready;
        if (!aresetn) begin
            sbq.delete();
        end else begin
            if (m_tvalid && m_tready) begin
                out_hs++;
                if (sbq.size() == 0) check("sb_unexpected_word", 32'(sbq.size()), 32'd1);
                else check("sb_word", m_tdata, sbq.pop_front());
            end
            if (last_acc) sbq.push_back(model(s_tdata, int'(mode), int'(shift)));
        end
        @(posedge aclk);
        #1;
        if (m_rand) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [1:0] sh);
        mode = m;
        shift = sh;
        s_tdata = d;
        s_tvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sbq.size() == 0) break;
            tick();
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    logic [31:0] vec_exp [4];
    logic [1:0]  vec_mode [4];
    logic [1:0]  vec_shift [4];
    logic [31:0] wc_exp [3];

    initial begin
        int nxt;
        int hs_start;
        logic [1:0] md;

        mode = 2'd0; shift = 2'd0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        mode2 = 2'd0; shift2 = 1'b0; s2_tdata = '0; s2_tvalid = 1'b0;
        vec_mode  = '{2'd1, 2'd1, 2'd2, 2'd3};
        vec_shift = '{2'd1, 2'd3, 2'd0, 2'd2};
        vec_exp   = '{32'h11443322, 32'h33221144, 32'h11223344, 32'h33333333};
        wc_exp    = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        #22;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_word_count", word_count, 32'd0);
        aresetn = 1'b1;
        #1;
        check("pre_edge_s_tready", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("first_edge_s_tready", 32'(s_tready), 32'd1);

        // pass mode, one-cycle latency, then counter
        send(32'h44332211, 2'd0, 2'd0);
        check("latency_m_tvalid", 32'(m_tvalid), 32'd1);
        check("pass_data", m_tdata, 32'h44332211);
        tick();
        check("word_count_one", word_count, 32'd1);

        for (int v = 0; v < 4; v++) begin
            send(32'h44332211, vec_mode[v], vec_shift[v]);
            check("map_vector", m_tdata, vec_exp[v]);
        end
        drain();

        // legacy two-lane half swap
        s2_tdata = 32'hAAAA5555; mode2 = 2'd1; shift2 = 1'b1; s2_tvalid = 1'b1;
        tick();
        s2_tvalid = 1'b0;
        check("legacy_m_tvalid", 32'(m2_tvalid), 32'd1);
        check("legacy_swap", m2_tdata, 32'h5555AAAA);

        // backpressure: hold downstream for 5 cycles under continuous input
        m_tready = 1'b0;
        mode = 2'd0;
        nxt = 1;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_tdata = 32'(nxt);
            tick();
            if (last_acc) nxt++;
        end
        check("bp_s_tready_low", 32'(s_tready), 32'd0);
        check("bp_words_buffered", 32'(nxt - 1), 32'd2);
        check("bp_m_tvalid", 32'(m_tvalid), 32'd1);
        check("bp_m_tdata_hold", m_tdata, 32'd1);
        m_tready = 1'b1;
        hs_start = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) hs_start = out_hs;
            s_tdata = 32'(nxt);
            tick();
            if (last_acc) nxt++;
            if (c == 9) check("throughput_8_of_8", 32'(out_hs - hs_start), 32'd8);
        end
        s_tvalid = 1'b0;
        drain();

        // config toggled every cycle under random downstream stalls
        m_rand = 1'b1;
        md = 2'd0;
        for (int w = 0; w < 16; w++) begin
            s_tdata = $urandom;
            shift = 2'($urandom_range(0, 3));
            s_tvalid = 1'b1;
            for (int k = 0; k < 100; k++) begin
                mode = md;
                md = md ^ 2'd2;
                tick();
                if (last_acc) break;
            end
            if (!last_acc) check("toggle_timeout", 32'(last_acc), 32'd1);
        end
        s_tvalid = 1'b0;
        m_rand = 1'b0;
        m_tready = 1'b1;
        drain();

        // reset with the buffer full
        m_tready = 1'b0;
        mode = 2'd0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_tdata = 32'hC0DE0000 + 32'(c);
            tick();
        end
        check("full_s_tready", 32'(s_tready), 32'd0);
        check("full_m_tvalid", 32'(m_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        #1;
        check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_s_tready", 32'(s_tready), 32'd0);
        check("midrst_word_count", word_count, 32'd0);
        for (int c = 0; c < 3; c++) tick();
        check("midrst_hold_m_tvalid", 32'(m_tvalid), 32'd0);
        #2;
        aresetn = 1'b1;
        check("post_rst_pre_edge", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("post_rst_s_tready", 32'(s_tready), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        check("no_stale_m_tvalid", 32'(m_tvalid), 32'd0);
        check("no_stale_word_count", word_count, 32'd0);

        // counter wrap
        force dut.cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.cnt_q;
        for (int i = 0; i < 3; i++) begin
            send(32'h100 + 32'(i), 2'd0, 2'd0);
            tick();
            check("word_count_wrap", word_count, wc_exp[i]);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_lane_switch.md
Name: axis_lane_switch

Overview:
- Parameterised AXI-Stream lane router; successor to the fixed two-half swap stage in the ADC/DAC data path.
- Splits each word into LANE_COUNT equal lanes and applies one of four per-word lane mappings: pass, rotate, reverse or broadcast.
- Registered, full-throughput output stage with a 2-entry skid buffer; no combinational path between the slave and master sides.
- Also provides a free-running transfer counter for the status register bank.

Parameters:
- AXIS_TDATA_WIDTH, 32: stream word width; must be a multiple of LANE_COUNT.
- LANE_COUNT, 2: number of lanes; power of two, >= 2.
- LANE_WIDTH, AXIS_TDATA_WIDTH/LANE_COUNT: derived local parameter, not overridable.
- SEL_WIDTH, clog2(LANE_COUNT): derived local parameter; width of the shift input.

Ports:
- aclk  in  1  system clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- mode  in  2  lane mapping: 0 pass, 1 rotate, 2 reverse, 3 broadcast.
- shift  in  SEL_WIDTH  rotate amount (mode 1) or source lane (mode 3).
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  input word.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  input ready; registered.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  mapped word; registered.
- M_AXIS_tvalid  out  1  output valid; registered.
- word_count  out  32  number of completed master handshakes.

Behaviour:
- Clock and reset: one clock, aclk; reset is asynchronous and active-low (aresetn).
- Reset values: S_AXIS_tready=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, skid entry empty, word_count=0.
- Ready after reset: S_AXIS_tready rises on the first aclk edge after aresetn deasserts.
- Reset mid-operation: any buffered words are discarded; no output handshake may complete while aresetn is low.
- Lane numbering: lane i = bits [i*LANE_WIDTH +: LANE_WIDTH].
- Lane mapping (out lane i, in lane j):
  - mode 0: j = i.
  - mode 1: j = (i+shift) mod LANE_COUNT.
  - mode 2: j = LANE_COUNT-1-i.
  - mode 3: j = shift for all i.
- Legacy equivalence: with LANE_COUNT=2, mode 1 and shift=1 give the legacy half-swap; mode 0 gives the legacy pass-through.
- Config sampling: mode and shift are sampled in the same cycle as the input handshake (S_AXIS_tvalid & S_AXIS_tready). The mapping is applied before buffering, so a config change never affects words already accepted. Changing config every cycle is legal.
- Latency: 1 cycle from input handshake to M_AXIS_tvalid when the output register is empty or being drained.
- Throughput: 1 word/cycle sustained while M_AXIS_tready=1.
- Buffering uses an output register (OUT) and a skid register (SKID). States are derived from the valid bits, with state EMPTY held through reset:
  - EMPTY (OUT and SKID invalid): accept goes to OUT, next state ONE.
  - ONE (OUT valid):
    - accept with M ready: OUT replaced, stay ONE.
    - accept without M ready: word goes to SKID, next state FULL.
    - M ready with no accept: next state EMPTY.
  - FULL (both valid): S_AXIS_tready=0 from the cycle after entry.
    - M ready: SKID moves to OUT, next state ONE, S_AXIS_tready returns to 1 on that edge.
    - M not ready: hold.
- Readiness: S_AXIS_tready is registered as NOT(next SKID valid) and is never combinationally dependent on M_AXIS_tready.
- Ordering: words leave in acceptance order. No word is dropped or duplicated under any tvalid/tready pattern.
- Output stability: M_AXIS_tdata is held stable while M_AXIS_tvalid=1 and M_AXIS_tready=0 (AXIS rule).
- word_count: increments by 1 on each M_AXIS_tvalid & M_AXIS_tready; wraps from 0xFFFFFFFF to 0.

Test Plan:
- LANE_COUNT=4, mode 0, in 0x44332211 -> out 0x44332211 one cycle after the handshake; word_count=1.
- mode 1, shift 1, in 0x44332211 -> out 0x11443322. shift 3 -> 0x33221144.
- mode 2 -> 0x11223344. mode 3, shift 2 -> 0x33333333. With LANE_COUNT=2, mode 1, shift 1, in 0xAAAA5555 -> 0x5555AAAA.
- Backpressure: continuous input 1,2,3,...; hold M_AXIS_tready=0 for 5 cycles.
  - Expected: S_AXIS_tready drops after two words are buffered.
  - After release, output sequence is exactly 1,2,3,... with no gaps or duplicates; 1 word/cycle when both sides are ready.
- Config toggled between mode 0 and mode 2 every cycle during a 16-word burst with random stalls -> each output word matches the mode sampled at its own input handshake.
- Reset mid-burst with the FULL state reached:
  - During reset: M_AXIS_tvalid=0, S_AXIS_tready=0, word_count=0.
  - After release: tready=1 on the first edge, and no stale word appears.
- word_count preloaded to 0xFFFFFFFE via force, then 3 transfers -> 0xFFFFFFFF, 0, 1.
